// File: rtl/bus_arbiter_nx1_pkg.sv
// Shared types and helpers for the N:1 bus arbiter.
// State encoding and a constant-safe clog2.
package bus_arbiter_nx1_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RELEASE = 2'b10
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_nx1_picker.sv
// Round-robin priority picker: first set request at or after ptr.
// Rotate, priority-encode, un-rotate; purely combinational.
module rr_priority_picker
    import bus_arbiter_nx1_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate so that bit 0 is the master at ptr
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
    end

    // Lowest set bit of the rotated vector wins
    always_comb begin
        off       = '0;
        gnt_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off       = IW'(i);
                gnt_valid = 1'b1;
            end
        end
    end

    // Map the winning offset back to a master index
    always_comb begin
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        gnt_idx = sum[IW-1:0];
    end

endmodule

// File: rtl/bus_arbiter_nx1.sv
// N-master to 1-slave bus arbiter, round-robin with per-grant timeout.
// Request fields and responses are registered one cycle each way.
module bus_arbiter_nx1
    import bus_arbiter_nx1_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 0,
    localparam int BE_W       = DATA_W / 8,
    localparam int IW         = clog2(N_MASTERS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_MASTERS-1:0]        i_bus_en,
    input  logic [N_MASTERS-1:0]        i_wr_rd,
    input  logic [N_MASTERS*DATA_W-1:0] i_wr_data,
    input  logic [N_MASTERS*ADDR_W-1:0] i_addr,
    input  logic [N_MASTERS*BE_W-1:0]   i_byte_en,
    output logic [N_MASTERS-1:0]        o_ack,
    output logic [N_MASTERS-1:0]        o_err,
    output logic [N_MASTERS*DATA_W-1:0] o_rd_data,
    input  logic                        i_ack,
    input  logic [DATA_W-1:0]           i_rd_data,
    output logic                        o_bus_en,
    output logic                        o_wr_en,
    output logic [DATA_W-1:0]           o_wr_data,
    output logic [ADDR_W-1:0]           o_addr,
    output logic [BE_W-1:0]             o_byte_en,
    output logic                        o_grant_valid,
    output logic [IW-1:0]               o_grant_idx
);

    localparam int CW = clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC);

    arb_state_e state_q, state_d;

    logic [IW-1:0]               grant_q, grant_d;
    logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [N_MASTERS-1:0]        ack_q, ack_d;
    logic [N_MASTERS-1:0]        err_q, err_d;
    logic [N_MASTERS*DATA_W-1:0] rd_data_q, rd_data_d;
    logic                        bus_en_q, bus_en_d;
    logic                        wr_en_q, wr_en_d;
    logic [DATA_W-1:0]           wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [BE_W-1:0]             byte_en_q, byte_en_d;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic              sel_en;
    logic              sel_wr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic              busy;
    logic              to_hit;
    logic              ack_ev;
    logic              to_ev;
    logic              abort_ev;
    logic [IW-1:0]     g_next;

    rr_priority_picker #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req       (i_bus_en),
        .ptr       (rr_ptr_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Select the granted master's request fields
    always_comb begin
        sel_en    = 1'b0;
        sel_wr    = 1'b0;
        sel_wdata = '0;
        sel_addr  = '0;
        sel_be    = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (grant_q == IW'(m)) begin
                sel_en    = i_bus_en[m];
                sel_wr    = i_wr_rd[m];
                sel_wdata = i_wr_data[m*DATA_W +: DATA_W];
                sel_addr  = i_addr[m*ADDR_W +: ADDR_W];
                sel_be    = i_byte_en[m*BE_W +: BE_W];
            end
        end
    end

    // Ack beats timeout; a vanished master aborts before timing out
    assign busy     = (state_q == BUSY);
    assign to_hit   = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
    assign ack_ev   = busy && i_ack;
    assign abort_ev = busy && !i_ack && !sel_en;
    assign to_ev    = busy && !i_ack && sel_en && to_hit;
    assign g_next   = (grant_q == IW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) state_d = BUSY;
            end
            BUSY: begin
                if (ack_ev || to_ev) begin
                    state_d = RELEASE;
                end else if (abort_ev) begin
                    state_d = IDLE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        err_d     = '0;
        rd_data_d = '0;
        bus_en_d  = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = '0;
        addr_d    = '0;
        byte_en_d = '0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (pick_valid) grant_d = pick_idx;
        end
        if (busy) begin
            bus_en_d  = sel_en && !i_ack && !to_hit;
            wr_en_d   = sel_wr;
            wr_data_d = sel_wdata;
            addr_d    = sel_addr;
            byte_en_d = sel_be;
            if (cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
            if (ack_ev || to_ev || abort_ev) rr_ptr_d = g_next;
            for (int m = 0; m < N_MASTERS; m++) begin
                if (grant_q == IW'(m)) begin
                    if (ack_ev) begin
                        ack_d[m] = 1'b1;
                        rd_data_d[m*DATA_W +: DATA_W] = i_rd_data;
                    end
                    if (to_ev) begin
                        ack_d[m] = 1'b1;
                        err_d[m] = 1'b1;
                    end
                end
            end
        end
    end

    // Datapath and response registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rd_data_q <= '0;
            bus_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            addr_q    <= '0;
            byte_en_q <= '0;
        end else begin
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            bus_en_q  <= bus_en_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            addr_q    <= addr_d;
            byte_en_q <= byte_en_d;
        end
    end

    assign o_ack         = ack_q;
    assign o_err         = err_q;
    assign o_rd_data     = rd_data_q;
    assign o_bus_en      = bus_en_q;
    assign o_wr_en       = wr_en_q;
    assign o_wr_data     = wr_data_q;
    assign o_addr        = addr_q;
    assign o_byte_en     = byte_en_q;
    assign o_grant_valid = busy;
    assign o_grant_idx   = grant_q;

endmodule

// File: tb/tb_bus_arbiter_nx1.sv
// Directed bench for bus_arbiter_nx1 (4 masters, 8-cycle timeout).
// Expected values are hand-derived cycle by cycle.
module tb_bus_arbiter_nx1;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 8;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_bus_en;
    logic [N-1:0]    i_wr_rd;
    logic [N*DW-1:0] i_wr_data;
    logic [N*AW-1:0] i_addr;
    logic [N*BW-1:0] i_byte_en;
    logic [N-1:0]    o_ack;
    logic [N-1:0]    o_err;
    logic [N*DW-1:0] o_rd_data;
    logic            i_ack;
    logic [DW-1:0]   i_rd_data;
    logic            o_bus_en;
    logic            o_wr_en;
    logic [DW-1:0]   o_wr_data;
    logic [AW-1:0]   o_addr;
    logic [BW-1:0]   o_byte_en;
    logic            o_grant_valid;
    logic [1:0]      o_grant_idx;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter_nx1 #(
        .N_MASTERS   (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_bus_en      (i_bus_en),
        .i_wr_rd       (i_wr_rd),
        .i_wr_data     (i_wr_data),
        .i_addr        (i_addr),
        .i_byte_en     (i_byte_en),
        .o_ack         (o_ack),
        .o_err         (o_err),
        .o_rd_data     (o_rd_data),
        .i_ack         (i_ack),
        .i_rd_data     (i_rd_data),
        .o_bus_en      (o_bus_en),
        .o_wr_en       (o_wr_en),
        .o_wr_data     (o_wr_data),
        .o_addr        (o_addr),
        .o_byte_en     (o_byte_en),
        .o_grant_valid (o_grant_valid),
        .o_grant_idx   (o_grant_idx)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic wr,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] wd,
                         input logic [BW-1:0] be);
        i_wr_rd[m]             = wr;
        i_addr[m*AW +: AW]     = a;
        i_wr_data[m*DW +: DW]  = wd;
        i_byte_en[m*BW +: BW]  = be;
    endtask

    // From IDLE: grant g, ack immediately, release, optionally re-request
    task automatic xfer(input int g, input logic [DW-1:0] rd,
                        input bit rearm);
        logic [127:0] oh;
        oh = 128'(1) << g;
        tick;
        check("grant_valid", 128'(o_grant_valid), 128'(1));
        check("grant_idx", 128'(o_grant_idx), 128'(g));
        i_ack     = 1'b1;
        i_rd_data = rd;
        tick;
        check("ack", 128'(o_ack), oh);
        check("rd_data", 128'(o_rd_data[g*DW +: DW]), 128'(rd));
        check("release_valid", 128'(o_grant_valid), 128'(0));
        i_ack       = 1'b0;
        i_bus_en[g] = 1'b0;
        tick;
        check("ack_pulse", 128'(o_ack), 128'(0));
        if (rearm) i_bus_en[g] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst     = 1'b0;
        i_bus_en  = '0;
        i_wr_rd   = '0;
        i_wr_data = '0;
        i_addr    = '0;
        i_byte_en = '0;
        i_ack     = 1'b0;
        i_rd_data = '0;
        for (int m = 0; m < N; m++) set_m(m, 1'b0, 32'h10 * m, 0, 4'hF);
        tick;
        tick;
        check("rst_ack", 128'(o_ack), 128'(0));
        check("rst_bus_en", 128'(o_bus_en), 128'(0));
        check("rst_valid", 128'(o_grant_valid), 128'(0));
        check("rst_idx", 128'(o_grant_idx), 128'(0));
        check("rst_rd_data", o_rd_data, 128'(0));
        i_rst = 1'b1;
        tick;

        // Fairness: all request, immediate ack -> 0,1,2,3,0
        i_bus_en = 4'hF;
        xfer(0, 32'hA000_0000, 1'b1);
        xfer(1, 32'hA000_0001, 1'b1);
        xfer(2, 32'hA000_0002, 1'b1);
        xfer(3, 32'hA000_0003, 1'b1);
        xfer(0, 32'hA000_0010, 1'b0);
        i_bus_en = '0;
        tick;
        check("idle_after_fair", 128'(o_grant_valid), 128'(0));

        // Single master m2 read, slave acks 3 cycles after o_bus_en
        set_m(2, 1'b0, 32'h100, 0, 4'hF);
        i_bus_en = 4'b0100;
        tick;
        check("m2_valid", 128'(o_grant_valid), 128'(1));
        check("m2_idx", 128'(o_grant_idx), 128'(2));
        check("m2_bus_en_lat", 128'(o_bus_en), 128'(0));
        tick;
        check("m2_bus_en", 128'(o_bus_en), 128'(1));
        check("m2_addr", 128'(o_addr), 128'h100);
        check("m2_wr_en", 128'(o_wr_en), 128'(0));
        check("m2_be", 128'(o_byte_en), 128'hF);
        for (int k = 0; k < 2; k++) begin
            tick;
            check("m2_wait_ack", 128'(o_ack), 128'(0));
            check("m2_wait_en", 128'(o_bus_en), 128'(1));
        end
        i_ack     = 1'b1;
        i_rd_data = 32'hDEAD_BEEF;
        tick;
        check("m2_ack", 128'(o_ack), 128'b0100);
        check("m2_rd_data", o_rd_data, 128'hDEAD_BEEF << 64);
        check("m2_err", 128'(o_err), 128'(0));
        check("m2_en_drop", 128'(o_bus_en), 128'(0));
        i_ack    = 1'b0;
        i_bus_en = '0;
        tick;
        check("m2_ack_pulse", 128'(o_ack), 128'(0));

        // Wrap: rr_ptr=3, m0 and m3 -> m3 then m0
        i_bus_en = 4'b1001;
        xfer(3, 32'h3333_0003, 1'b0);
        xfer(0, 32'h0000_0A0A, 1'b0);

        // Timeout: m1 write, no ack for 8 BUSY cycles; m3 waiting
        set_m(1, 1'b1, 32'h200, 32'hCAFE_0001, 4'h3);
        set_m(3, 1'b0, 32'h300, 0, 4'hF);
        i_bus_en = 4'b1010;
        tick;
        check("to_idx", 128'(o_grant_idx), 128'(1));
        tick;
        check("to_wr_en", 128'(o_wr_en), 128'(1));
        check("to_addr", 128'(o_addr), 128'h200);
        check("to_wdata", 128'(o_wr_data), 128'hCAFE_0001);
        for (int k = 0; k < 6; k++) begin
            tick;
            check("to_wait_ack", 128'(o_ack), 128'(0));
            check("to_wait_en", 128'(o_bus_en), 128'(1));
        end
        tick;
        check("to_ack", 128'(o_ack), 128'b0010);
        check("to_err", 128'(o_err), 128'b0010);
        check("to_en_drop", 128'(o_bus_en), 128'(0));
        check("to_rd_data", o_rd_data, 128'(0));
        i_bus_en[1] = 1'b0;
        tick;
        check("to_err_pulse", 128'(o_err), 128'(0));
        xfer(3, 32'h3333_3333, 1'b0);

        // Abort: m0 drops request while BUSY
        i_bus_en = 4'b0001;
        tick;
        check("ab_idx", 128'(o_grant_idx), 128'(0));
        tick;
        check("ab_bus_en", 128'(o_bus_en), 128'(1));
        i_bus_en = '0;
        tick;
        check("ab_valid", 128'(o_grant_valid), 128'(0));
        check("ab_ack", 128'(o_ack), 128'(0));
        check("ab_en", 128'(o_bus_en), 128'(0));
        tick;
        check("ab_ack2", 128'(o_ack), 128'(0));

        // Stray ack in IDLE
        i_ack     = 1'b1;
        i_rd_data = 32'hFFFF_FFFF;
        tick;
        check("stray_ack", 128'(o_ack), 128'(0));
        check("stray_rd", o_rd_data, 128'(0));
        i_ack = 1'b0;
        tick;
        check("stray_ack2", 128'(o_ack), 128'(0));

        // Reset mid-transfer with simultaneous ack
        i_bus_en = 4'b0010;
        tick;
        check("rm_idx", 128'(o_grant_idx), 128'(1));
        tick;
        check("rm_bus_en", 128'(o_bus_en), 128'(1));
        i_ack = 1'b1;
        i_rst = 1'b0;
        tick;
        check("rm_ack", 128'(o_ack), 128'(0));
        check("rm_err", 128'(o_err), 128'(0));
        check("rm_en", 128'(o_bus_en), 128'(0));
        check("rm_valid", 128'(o_grant_valid), 128'(0));
        check("rm_idx0", 128'(o_grant_idx), 128'(0));
        check("rm_addr", 128'(o_addr), 128'(0));
        check("rm_rd", o_rd_data, 128'(0));
        i_rst    = 1'b1;
        i_ack    = 1'b0;
        i_bus_en = 4'b1001;
        xfer(0, 32'h1234_5678, 1'b0);
        xfer(3, 32'h8765_4321, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
